// File: rtl/reg_wb_queue_if.sv
// Write-back queue bus: ALU/load write requests, register-file write port
// and forwarding lookup. master = pipeline side, slave = queue side.
interface reg_wb_queue_if;
  logic        ex_valid;
  logic [1:0]  ex_spec;
  logic [2:0]  ex_dest;
  logic [15:0] ex_data;

  logic        mem_valid;
  logic [1:0]  mem_spec;
  logic [2:0]  mem_dest;
  logic [15:0] mem_data;

  logic        wb_ready;

  logic        regWrite;
  logic [1:0]  writeSpecReg;
  logic [2:0]  R3;
  logic [15:0] inData3;

  logic [1:0]  fwd_spec;
  logic [2:0]  fwd_idx;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  modport master (
    output ex_valid, ex_spec, ex_dest, ex_data,
    output mem_valid, mem_spec, mem_dest, mem_data,
    output fwd_spec, fwd_idx,
    input  wb_ready,
    input  regWrite, writeSpecReg, R3, inData3,
    input  fwd_hit, fwd_data
  );

  modport slave (
    input  ex_valid, ex_spec, ex_dest, ex_data,
    input  mem_valid, mem_spec, mem_dest, mem_data,
    input  fwd_spec, fwd_idx,
    output wb_ready,
    output regWrite, writeSpecReg, R3, inData3,
    output fwd_hit, fwd_data
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Register write-back queue: merges ALU (ex) and load (mem) results into one
// register-file write per cycle, with an optional forwarding lookup.
// Ports: CLK, RST_N (async, active-low), bus (reg_wb_queue_if.slave):
//   ex_*/mem_* requests in, wb_ready out, regWrite/writeSpecReg/R3/inData3
//   write port out, fwd_spec/fwd_idx key in, fwd_hit/fwd_data out.
// Option: define REG_WB_QUEUE_FWD_EN to build the forwarding lookup.
module reg_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  reg_wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]  spec;
    logic [2:0]  dest;
    logic [15:0] data;
  } wb_ent_t;

  wb_ent_t       r_q [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_wr;
  wb_ent_t       r_out;

  logic          w_ready;
  logic          w_acc_mem;
  logic          w_acc_ex;
  logic          w_pop;
  logic [CW-1:0] w_n_acc;
  logic [AW-1:0] w_ex_slot;
  wb_ent_t       w_mem_ent;
  wb_ent_t       w_ex_ent;

  // Two free slots guarantee a dual accept never overflows.
  assign w_ready   = (r_count <= CW'(DEPTH - 2));
  assign w_acc_mem = bus.mem_valid & w_ready;
  assign w_acc_ex  = bus.ex_valid & w_ready;
  assign w_pop     = (r_count != '0);
  assign w_n_acc   = CW'(w_acc_mem) + CW'(w_acc_ex);

  // mem is the older instruction, so it takes the first free slot.
  assign w_ex_slot = w_acc_mem ? r_tail + AW'(1) : r_tail;

  assign w_mem_ent = '{
    spec: bus.mem_spec,
    dest: bus.mem_dest,
    data: bus.mem_data
  };
  assign w_ex_ent = '{
    spec: bus.ex_spec,
    dest: bus.ex_dest,
    data: bus.ex_data
  };

  always_ff @(posedge CLK) begin
    if (w_acc_mem) r_q[r_tail] <= w_mem_ent;
    if (w_acc_ex) r_q[w_ex_slot] <= w_ex_ent;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop);
      r_tail  <= r_tail + AW'(w_n_acc);
      r_count <= r_count + w_n_acc - CW'(w_pop);
    end
  end

  // Output register; fields hold when nothing is popped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr  <= 1'b0;
      r_out <= '0;
    end else begin
      r_wr <= w_pop;
      if (w_pop) r_out <= r_q[r_head];
    end
  end

  assign bus.wb_ready     = w_ready;
  assign bus.regWrite     = r_wr;
  assign bus.writeSpecReg = r_out.spec;
  assign bus.R3           = r_out.dest;
  assign bus.inData3      = r_out.data;

`ifdef REG_WB_QUEUE_FWD_EN
  logic        w_hit;
  logic [15:0] w_fdata;

  // Dest only distinguishes general registers; SP/IH/T are single.
  function automatic logic f_match(
    input wb_ent_t    e,
    input logic [1:0] k_spec,
    input logic [2:0] k_idx
  );
    return (e.spec == k_spec) &&
           ((k_spec != 2'b00) || (e.dest == k_idx));
  endfunction

  // Scan oldest to newest so the newest match overwrites older ones;
  // the output register is older than anything still queued.
  always_comb begin
    w_hit   = 1'b0;
    w_fdata = '0;
    if (r_wr && f_match(r_out, bus.fwd_spec, bus.fwd_idx)) begin
      w_hit   = 1'b1;
      w_fdata = r_out.data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) &&
          f_match(r_q[r_head + AW'(i)], bus.fwd_spec, bus.fwd_idx)) begin
        w_hit   = 1'b1;
        w_fdata = r_q[r_head + AW'(i)].data;
      end
    end
  end

  assign bus.fwd_hit  = w_hit;
  assign bus.fwd_data = w_fdata;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.fwd_spec, bus.fwd_idx};
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif
endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_reg_wb_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  spec;
    logic [2:0]  dest;
    logic [15:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_queue_if bus ();

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  ent_t mq[$];
  logic m_wr;
  ent_t m_out;
  int   n_chk;
  int   n_fail;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic bit m_match(ent_t e, logic [1:0] s, logic [2:0] d);
    return (e.spec == s) && (s != 2'b00 || e.dest == d);
  endfunction

  function automatic void m_fwd(output bit hit, output logic [15:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef REG_WB_QUEUE_FWD_EN
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (m_match(mq[i], bus.fwd_spec, bus.fwd_idx)) begin
        hit  = 1'b1;
        data = mq[i].data;
        return;
      end
    end
    if (m_wr && m_match(m_out, bus.fwd_spec, bus.fwd_idx)) begin
      hit  = 1'b1;
      data = m_out.data;
    end
`endif
  endfunction

  task automatic m_clear();
    mq.delete();
    m_wr  = 1'b0;
    m_out = '0;
  endtask

  task automatic idle();
    bus.ex_valid  = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic set_ex(logic [1:0] s, logic [2:0] d, logic [15:0] v);
    bus.ex_valid = 1'b1;
    bus.ex_spec  = s;
    bus.ex_dest  = d;
    bus.ex_data  = v;
  endtask

  task automatic set_mem(logic [1:0] s, logic [2:0] d, logic [15:0] v);
    bus.mem_valid = 1'b1;
    bus.mem_spec  = s;
    bus.mem_dest  = d;
    bus.mem_data  = v;
  endtask

  // One clock: model pops the head into the write port, then
  // enqueues accepted requests, mem before ex.
  task automatic tick();
    bit rdy;
    rdy = (mq.size() <= DEPTH - 2);
    @(posedge clk);
    if (!rst_n) begin
      m_clear();
    end else begin
      if (mq.size() > 0) begin
        m_out = mq.pop_front();
        m_wr  = 1'b1;
      end else begin
        m_wr = 1'b0;
      end
      if (rdy && bus.mem_valid)
        mq.push_back('{bus.mem_spec, bus.mem_dest, bus.mem_data});
      if (rdy && bus.ex_valid)
        mq.push_back('{bus.ex_spec, bus.ex_dest, bus.ex_data});
    end
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3 * DEPTH; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_clear();
    #12;
    n_chk += 6;
    if (bus.regWrite !== 1'b0) begin
      n_fail++; $display("FAIL rst_regWrite got %b want 0", bus.regWrite);
    end
    if (bus.writeSpecReg !== 2'b00) begin
      n_fail++; $display("FAIL rst_spec got %h want 0", bus.writeSpecReg);
    end
    if (bus.R3 !== 3'd0) begin
      n_fail++; $display("FAIL rst_R3 got %h want 0", bus.R3);
    end
    if (bus.inData3 !== 16'h0) begin
      n_fail++; $display("FAIL rst_data got %h want 0", bus.inData3);
    end
    if (bus.fwd_hit !== 1'b0) begin
      n_fail++; $display("FAIL rst_fwd_hit got %b want 0", bus.fwd_hit);
    end
    if (bus.wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready got %b want 1", bus.wb_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_ex(2'b00, 3'd3, 16'h1234);
    tick();
    idle();
    n_chk++;
    if (bus.regWrite !== 1'b0) begin
      n_fail++; $display("FAIL single_early got %b want 0", bus.regWrite);
    end
    tick();
    n_chk += 4;
    if (bus.regWrite !== 1'b1) begin
      n_fail++; $display("FAIL single_wr got %b want 1", bus.regWrite);
    end
    if (bus.writeSpecReg !== 2'b00) begin
      n_fail++; $display("FAIL single_spec got %h want 0", bus.writeSpecReg);
    end
    if (bus.R3 !== 3'd3) begin
      n_fail++; $display("FAIL single_R3 got %h want 3", bus.R3);
    end
    if (bus.inData3 !== 16'h1234) begin
      n_fail++; $display("FAIL single_data got %h want 1234", bus.inData3);
    end
    tick();
    n_chk += 2;
    if (bus.regWrite !== 1'b0) begin
      n_fail++; $display("FAIL single_after got %b want 0", bus.regWrite);
    end
    if (bus.inData3 !== 16'h1234) begin
      n_fail++; $display("FAIL single_hold got %h want 1234", bus.inData3);
    end
  endtask

  task automatic test_dual();
    set_mem(2'b01, 3'd5, 16'h00FF);
    set_ex(2'b00, 3'd1, 16'hAAAA);
    tick();
    idle();
    tick();
    n_chk += 3;
    if (bus.regWrite !== 1'b1) begin
      n_fail++; $display("FAIL dual_wr0 got %b want 1", bus.regWrite);
    end
    if (bus.writeSpecReg !== 2'b01) begin
      n_fail++; $display("FAIL dual_spec0 got %h want 1", bus.writeSpecReg);
    end
    if (bus.inData3 !== 16'h00FF) begin
      n_fail++; $display("FAIL dual_data0 got %h want 00ff", bus.inData3);
    end
    tick();
    n_chk += 4;
    if (bus.regWrite !== 1'b1) begin
      n_fail++; $display("FAIL dual_wr1 got %b want 1", bus.regWrite);
    end
    if (bus.writeSpecReg !== 2'b00) begin
      n_fail++; $display("FAIL dual_spec1 got %h want 0", bus.writeSpecReg);
    end
    if (bus.R3 !== 3'd1) begin
      n_fail++; $display("FAIL dual_R3 got %h want 1", bus.R3);
    end
    if (bus.inData3 !== 16'hAAAA) begin
      n_fail++; $display("FAIL dual_data1 got %h want aaaa", bus.inData3);
    end
    tick();
    n_chk++;
    if (bus.regWrite !== 1'b0) begin
      n_fail++; $display("FAIL dual_after got %b want 0", bus.regWrite);
    end
  endtask

  // Both sources hold three requests each; acceptance order must be
  // m0 e0 m1 e1 m2 e2 whatever the stalls.
  task automatic test_full();
    ent_t exl[$];
    ent_t meml[$];
    logic [15:0] order[$];
    int   writes;
    bit   saw_low;
    bit   rdy;
    for (int i = 0; i < 3; i++) begin
      meml.push_back('{2'($urandom), 3'($urandom), 16'($urandom)});
      exl.push_back('{2'($urandom), 3'($urandom), 16'($urandom)});
      order.push_back(meml[i].data);
      order.push_back(exl[i].data);
    end
    writes  = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 40; c++) begin
      idle();
      if (meml.size() > 0) set_mem(meml[0].spec, meml[0].dest, meml[0].data);
      if (exl.size() > 0) set_ex(exl[0].spec, exl[0].dest, exl[0].data);
      rdy = (mq.size() <= DEPTH - 2);
      n_chk++;
      if (bus.wb_ready !== rdy) begin
        n_fail++; $display("FAIL full_ready got %b want %b", bus.wb_ready, rdy);
      end
      if (!rdy && mq.size() == DEPTH - 1) saw_low = 1'b1;
      tick();
      if (rdy && meml.size() > 0) void'(meml.pop_front());
      if (rdy && exl.size() > 0) void'(exl.pop_front());
      n_chk++;
      if (bus.regWrite !== m_wr) begin
        n_fail++; $display("FAIL full_wr got %b want %b", bus.regWrite, m_wr);
      end
      if (m_wr) begin
        n_chk++;
        if (writes < 6 && bus.inData3 !== order[writes]) begin
          n_fail++;
          $display("FAIL full_order got %h want %h", bus.inData3, order[writes]);
        end
        writes++;
      end
      if (meml.size() == 0 && exl.size() == 0 && mq.size() == 0 && !m_wr)
        break;
    end
    idle();
    n_chk += 2;
    if (writes != 6) begin
      n_fail++; $display("FAIL full_count got %0d want 6", writes);
    end
    if (!saw_low) begin
      n_fail++; $display("FAIL full_stall got 0 want 1");
    end
  endtask

  task automatic test_fwd();
    bit exp_hit;
    logic [15:0] exp_d;
    set_mem(2'b00, 3'd2, 16'h1111);
    set_ex(2'b00, 3'd2, 16'h2222);
    tick();
    idle();
    bus.fwd_spec = 2'b00;
    bus.fwd_idx  = 3'd2;
    #1;
`ifdef REG_WB_QUEUE_FWD_EN
    exp_hit = 1'b1; exp_d = 16'h2222;
`else
    exp_hit = 1'b0; exp_d = 16'h0000;
`endif
    n_chk += 2;
    if (bus.fwd_hit !== exp_hit) begin
      n_fail++; $display("FAIL fwd_hit got %b want %b", bus.fwd_hit, exp_hit);
    end
    if (bus.fwd_data !== exp_d) begin
      n_fail++; $display("FAIL fwd_data got %h want %h", bus.fwd_data, exp_d);
    end
    bus.fwd_spec = 2'b10;
    bus.fwd_idx  = 3'($urandom);
    #1;
    n_chk += 2;
    if (bus.fwd_hit !== 1'b0) begin
      n_fail++; $display("FAIL fwd_ih_hit got %b want 0", bus.fwd_hit);
    end
    if (bus.fwd_data !== 16'h0) begin
      n_fail++; $display("FAIL fwd_ih_data got %h want 0", bus.fwd_data);
    end
    bus.fwd_spec = 2'b00;
    bus.fwd_idx  = 3'd2;
    for (int c = 0; c < 4; c++) begin
      tick();
      m_fwd(exp_hit, exp_d);
      n_chk += 3;
      if (bus.fwd_hit !== exp_hit) begin
        n_fail++; $display("FAIL fwd_seq_hit got %b want %b", bus.fwd_hit, exp_hit);
      end
      if (bus.fwd_data !== exp_d) begin
        n_fail++; $display("FAIL fwd_seq_data got %h want %h", bus.fwd_data, exp_d);
      end
      if (bus.regWrite !== m_wr) begin
        n_fail++; $display("FAIL fwd_seq_wr got %b want %b", bus.regWrite, m_wr);
      end
    end
  endtask

  task automatic test_random();
    bit exp_hit;
    logic [15:0] exp_d;
    bit rdy;
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        set_mem(2'($urandom), 3'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 1) == 1)
        set_ex(2'($urandom), 3'($urandom_range(0, 3)), 16'($urandom));
      bus.fwd_spec = 2'($urandom);
      bus.fwd_idx  = 3'($urandom_range(0, 3));
      #1;
      rdy = (mq.size() <= DEPTH - 2);
      m_fwd(exp_hit, exp_d);
      n_chk += 3;
      if (bus.wb_ready !== rdy) begin
        n_fail++; $display("FAIL rnd_ready got %b want %b", bus.wb_ready, rdy);
      end
      if (bus.fwd_hit !== exp_hit) begin
        n_fail++; $display("FAIL rnd_fwd_hit got %b want %b", bus.fwd_hit, exp_hit);
      end
      if (bus.fwd_data !== exp_d) begin
        n_fail++; $display("FAIL rnd_fwd_data got %h want %h", bus.fwd_data, exp_d);
      end
      tick();
      n_chk++;
      if ({bus.regWrite, bus.writeSpecReg, bus.R3, bus.inData3} !==
          {m_wr, m_out.spec, m_out.dest, m_out.data}) begin
        n_fail++;
        $display("FAIL rnd_write got %b/%h/%h/%h want %b/%h/%h/%h",
                 bus.regWrite, bus.writeSpecReg, bus.R3, bus.inData3,
                 m_wr, m_out.spec, m_out.dest, m_out.data);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drain();
    set_mem(2'b00, 3'd4, 16'h0A0A);
    set_ex(2'b11, 3'd0, 16'h0B0B);
    tick();
    set_mem(2'b10, 3'd0, 16'h0C0C);
    set_ex(2'b00, 3'd6, 16'h0D0D);
    tick();
    idle();
    n_chk++;
    if (mq.size() != 3) begin
      n_fail++; $display("FAIL rmid_setup got %0d want 3", mq.size());
    end
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    n_chk += 3;
    if (bus.regWrite !== 1'b0) begin
      n_fail++; $display("FAIL rmid_wr got %b want 0", bus.regWrite);
    end
    if (bus.inData3 !== 16'h0) begin
      n_fail++; $display("FAIL rmid_data got %h want 0", bus.inData3);
    end
    if (bus.wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_ready got %b want 1", bus.wb_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.regWrite !== 1'b0) begin
        n_fail++; $display("FAIL rmid_hold got %b want 0", bus.regWrite);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk += 2;
      if (bus.regWrite !== 1'b0) begin
        n_fail++; $display("FAIL rmid_post_wr got %b want 0", bus.regWrite);
      end
      if (bus.wb_ready !== 1'b1) begin
        n_fail++; $display("FAIL rmid_post_ready got %b want 1", bus.wb_ready);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_clear();
    idle();
    bus.ex_spec  = '0; bus.ex_dest  = '0; bus.ex_data  = '0;
    bus.mem_spec = '0; bus.mem_dest = '0; bus.mem_data = '0;
    bus.fwd_spec = '0; bus.fwd_idx  = '0;
    test_reset();
    test_single();
    test_dual();
    drain();
    test_full();
    drain();
    test_fwd();
    drain();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
